// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage.
// Holds the alu_ctrl operation encodings, the multiply/divide FSM state
// type and the internal multiply/divide operation selector.
package exec_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_MUL   = 4'd8;
    localparam logic [3:0] ALU_MULHU = 4'd9;
    localparam logic [3:0] ALU_DIVU  = 4'd10;
    localparam logic [3:0] ALU_REMU  = 4'd11;
    localparam logic [3:0] ALU_NOR   = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } md_op_e;

endpackage

// File: rtl/exec_stage_mc_if.sv
// Bus bundle between the ID/EX register, the execute stage and EX/MEM.
// master: upstream/driver side (instruction, forwarding sources in; results out)
// slave : execute stage side
interface exec_stage_mc_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_src;
    logic              branch;
    logic              reg_write;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              mem_reg_write;
    logic              wb_reg_write;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] wb_value;
    logic              out_valid;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_write;
    logic [DATA_W-1:0] out_result;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic              flush;

    modport master (
        output in_valid, alu_ctrl, alu_src, branch, reg_write, rs, rt, rd,
               read_data1, read_data2, imm, pc, mem_rd, wb_rd,
               mem_reg_write, wb_reg_write, mem_result, wb_value,
        input  in_ready, out_valid, out_rd, out_reg_write, out_result,
               branch_taken, branch_target, flush
    );

    modport slave (
        input  in_valid, alu_ctrl, alu_src, branch, reg_write, rs, rt, rd,
               read_data1, read_data2, imm, pc, mem_rd, wb_rd,
               mem_reg_write, wb_reg_write, mem_result, wb_value,
        output in_ready, out_valid, out_rd, out_reg_write, out_result,
               branch_taken, branch_target, flush
    );
endinterface

// File: rtl/exec_muldiv.sv
// Iterative multiply/divide unit: one shift-add (multiply) or one
// restoring-subtract (divide) step per cycle, DATA_W steps per operation.
// Ports: clk, rst_n; start/op/a/b launch an operation (honoured in IDLE);
// busy is high outside IDLE; done is high for the single DONE cycle, during
// which result holds the selected product half, quotient or remainder.
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  md_op_e            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_e            state_r;
    state_e            state_s;
    md_op_e            op_r;
    logic [DATA_W-1:0] hi_r;    // product high half / partial remainder
    logic [DATA_W-1:0] lo_r;    // multiplier then product low / dividend then quotient
    logic [DATA_W-1:0] b_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] hi_s;
    logic [DATA_W-1:0] lo_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   shifted_s;
    logic [DATA_W:0]   trial_s;
    logic              is_div_s;

    // Next-state logic for the IDLE -> BUSY -> DONE sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_BUSY;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_BUSY;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // One iteration step; a zero divisor naturally yields all-ones quotient
    // and the dividend as remainder, so no special case is needed.
    always_comb begin
        is_div_s  = (op_r == MD_DIVU) || (op_r == MD_REMU);
        sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(DATA_W+1){1'b0}});
        shifted_s = {hi_r, lo_r[DATA_W-1]};
        trial_s   = shifted_s - {1'b0, b_r};
        if (is_div_s) begin
            if (trial_s[DATA_W]) begin
                hi_s = shifted_s[DATA_W-1:0];
                lo_s = {lo_r[DATA_W-2:0], 1'b0};
            end else begin
                hi_s = trial_s[DATA_W-1:0];
                lo_s = {lo_r[DATA_W-2:0], 1'b1};
            end
        end else begin
            hi_s = sum_s[DATA_W:1];
            lo_s = {sum_s[0], lo_r[DATA_W-1:1]};
        end
    end

    // State, operand and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            op_r    <= MD_MUL;
            hi_r    <= {DATA_W{1'b0}};
            lo_r    <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        hi_r  <= {DATA_W{1'b0}};
                        lo_r  <= a;
                        b_r   <= b;
                        cnt_r <= CNT_W'(DATA_W);
                    end
                end
                S_BUSY: begin
                    hi_r  <= hi_s;
                    lo_r  <= lo_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result selection from the finished iteration registers
    always_comb begin
        case (op_r)
            MD_MUL:   result = lo_r;
            MD_MULHU: result = hi_r;
            MD_DIVU:  result = lo_r;
            MD_REMU:  result = hi_r;
            default:  result = {DATA_W{1'b0}};
        endcase
    end

    assign busy = (state_r != S_IDLE);
    assign done = (state_r == S_DONE);

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: operand forwarding (MEM over WB), single-cycle ALU,
// iterative multiply/divide, branch-if-equal resolution and EX/MEM register.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the
// ID/EX instruction with valid/ready, the MEM/WB forwarding sources, the
// registered EX/MEM outputs and the branch_taken/branch_target/flush pulse.
module exec_stage_mc
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    exec_stage_mc_if.slave bus
);
    logic [DATA_W-1:0] a_s;
    logic [DATA_W-1:0] rt_fwd_s;
    logic [DATA_W-1:0] b_s;
    logic [DATA_W-1:0] diff_s;
    logic [DATA_W-1:0] alu_s;
    logic              is_md_s;
    md_op_e            md_op_s;
    logic              accept_s;
    logic              md_start_s;
    logic              md_busy_s;
    logic              md_done_s;
    logic [DATA_W-1:0] md_result_s;
    logic              taken_s;
    logic [DATA_W-1:0] target_s;

    logic              out_valid_r;
    logic [REG_AW-1:0] out_rd_r;
    logic              out_reg_write_r;
    logic [DATA_W-1:0] out_result_r;
    logic              branch_taken_r;
    logic [DATA_W-1:0] branch_target_r;
    logic [REG_AW-1:0] pend_rd_r;
    logic              pend_we_r;

    // Forwarded operands; MEM wins over WB, register 0 never forwards
    always_comb begin
        if (bus.mem_reg_write && (bus.mem_rd != {REG_AW{1'b0}}) && (bus.mem_rd == bus.rs)) begin
            a_s = bus.mem_result;
        end else if (bus.wb_reg_write && (bus.wb_rd != {REG_AW{1'b0}}) && (bus.wb_rd == bus.rs)) begin
            a_s = bus.wb_value;
        end else begin
            a_s = bus.read_data1;
        end
        if (bus.mem_reg_write && (bus.mem_rd != {REG_AW{1'b0}}) && (bus.mem_rd == bus.rt)) begin
            rt_fwd_s = bus.mem_result;
        end else if (bus.wb_reg_write && (bus.wb_rd != {REG_AW{1'b0}}) && (bus.wb_rd == bus.rt)) begin
            rt_fwd_s = bus.wb_value;
        end else begin
            rt_fwd_s = bus.read_data2;
        end
        if (bus.alu_src) begin
            b_s = bus.imm;
        end else begin
            b_s = rt_fwd_s;
        end
    end

    assign diff_s = a_s - b_s;

    // Single-cycle ALU and multi-cycle operation decode
    always_comb begin
        alu_s   = {DATA_W{1'b0}};
        is_md_s = 1'b0;
        md_op_s = MD_MUL;
        case (bus.alu_ctrl)
            CTRL_W'(ALU_AND):   alu_s = a_s & b_s;
            CTRL_W'(ALU_OR):    alu_s = a_s | b_s;
            CTRL_W'(ALU_ADD):   alu_s = a_s + b_s;
            CTRL_W'(ALU_SUB):   alu_s = diff_s;
            CTRL_W'(ALU_SLT):   alu_s = {{(DATA_W-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            CTRL_W'(ALU_NOR):   alu_s = ~(a_s | b_s);
            CTRL_W'(ALU_MUL):   begin is_md_s = 1'b1; md_op_s = MD_MUL;   end
            CTRL_W'(ALU_MULHU): begin is_md_s = 1'b1; md_op_s = MD_MULHU; end
            CTRL_W'(ALU_DIVU):  begin is_md_s = 1'b1; md_op_s = MD_DIVU;  end
            CTRL_W'(ALU_REMU):  begin is_md_s = 1'b1; md_op_s = MD_REMU;  end
            default:            alu_s = {DATA_W{1'b0}};
        endcase
    end

    // A branch is always resolved in one cycle, even with a multi-cycle code
    assign accept_s   = bus.in_valid && !md_busy_s;
    assign md_start_s = accept_s && is_md_s && !bus.branch;
    assign taken_s    = accept_s && bus.branch && (diff_s == {DATA_W{1'b0}});
    assign target_s   = bus.pc + (bus.imm << 2);

    exec_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start_s),
        .op     (md_op_s),
        .a      (a_s),
        .b      (b_s),
        .busy   (md_busy_s),
        .done   (md_done_s),
        .result (md_result_s)
    );

    // EX/MEM register, branch pulse and destination held during multi-cycle ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r     <= 1'b0;
            out_rd_r        <= {REG_AW{1'b0}};
            out_reg_write_r <= 1'b0;
            out_result_r    <= {DATA_W{1'b0}};
            branch_taken_r  <= 1'b0;
            branch_target_r <= {DATA_W{1'b0}};
            pend_rd_r       <= {REG_AW{1'b0}};
            pend_we_r       <= 1'b0;
        end else begin
            branch_taken_r <= taken_s;
            if (taken_s) begin
                branch_target_r <= target_s;
            end
            if (md_done_s) begin
                out_valid_r     <= 1'b1;
                out_rd_r        <= pend_rd_r;
                out_reg_write_r <= pend_we_r;
                out_result_r    <= md_result_s;
            end else if (accept_s && !md_start_s) begin
                out_valid_r     <= 1'b1;
                out_rd_r        <= bus.rd;
                out_reg_write_r <= bus.reg_write && !bus.branch;
                out_result_r    <= alu_s;
            end else begin
                out_valid_r     <= 1'b0;
                out_reg_write_r <= 1'b0;
            end
            if (md_start_s) begin
                pend_rd_r <= bus.rd;
                pend_we_r <= bus.reg_write;
            end
        end
    end

    assign bus.in_ready      = !md_busy_s;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_rd        = out_rd_r;
    assign bus.out_reg_write = out_reg_write_r;
    assign bus.out_result    = out_result_r;
    assign bus.branch_taken  = branch_taken_r;
    assign bus.branch_target = branch_target_r;
    assign bus.flush         = branch_taken_r;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc: directed and randomized stimulus
// compared against a plain-arithmetic reference model.
module tb_exec_stage_mc;
    import exec_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exec_stage_mc_if #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) bus ();

    exec_stage_mc #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_pick(input logic [4:0] src, input logic [31:0] regv);
        if (bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == src) return bus.mem_result;
        if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == src) return bus.wb_value;
        return regv;
    endfunction

    function automatic logic [31:0] ref_a();
        return ref_pick(bus.rs, bus.read_data1);
    endfunction

    function automatic logic [31:0] ref_b();
        if (bus.alu_src) return bus.imm;
        return ref_pick(bus.rt, bus.read_data2);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
            4'd8:  return p[31:0];
            4'd9:  return p[63:32];
            4'd10: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd11: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_instr(input logic [3:0] c, input logic src, input logic br, input logic rw,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] im, input logic [31:0] p);
        bus.alu_ctrl   = c;
        bus.alu_src    = src;
        bus.branch     = br;
        bus.reg_write  = rw;
        bus.rs         = rs;
        bus.rt         = rt;
        bus.rd         = rd;
        bus.read_data1 = d1;
        bus.read_data2 = d2;
        bus.imm        = im;
        bus.pc         = p;
    endtask

    task automatic set_fwd(input logic [4:0] mrd, input logic mwe, input logic [31:0] mres,
                           input logic [4:0] wrd, input logic wwe, input logic [31:0] wval);
        bus.mem_rd        = mrd;
        bus.mem_reg_write = mwe;
        bus.mem_result    = mres;
        bus.wb_rd         = wrd;
        bus.wb_reg_write  = wwe;
        bus.wb_value      = wval;
    endtask

    task automatic clear_inputs();
        bus.in_valid = 1'b0;
        set_instr(4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_reg_write, bus.branch_taken, bus.flush} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000",
                     {bus.in_ready, bus.out_valid, bus.out_reg_write, bus.branch_taken, bus.flush});
        end
        checks++;
        if (bus.out_result !== 32'd0 || bus.branch_target !== 32'd0 || bus.out_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_data got result %h target %h rd %0d want 0", bus.out_result, bus.branch_target, bus.out_rd);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        set_instr(ALU_ADD, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 32'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd12) begin
            errors++;
            $display("FAIL add_result got valid %b result %0d want 1 12", bus.out_valid, bus.out_result);
        end
        checks++;
        if (bus.out_rd !== 5'd4 || bus.out_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL add_dest got rd %0d we %b want 4 1", bus.out_rd, bus.out_reg_write);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_reg_write !== 1'b0 || bus.out_result !== 32'd12) begin
            errors++;
            $display("FAIL add_hold got valid %b we %b result %0d want 0 0 12",
                     bus.out_valid, bus.out_reg_write, bus.out_result);
        end
    endtask

    task automatic test_forward();
        logic [31:0] want [2];
        want[0] = 32'hAA;
        want[1] = 32'hBB;
        for (int k = 0; k < 2; k++) begin
            set_instr(ALU_OR, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd5, 32'h11, 32'd0, 32'd0, 32'd0);
            set_fwd((k == 0) ? 5'd3 : 5'd0, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB);
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== want[k]) begin
                errors++;
                $display("FAIL fwd_priority_%0d got valid %b result %h want 1 %h", k, bus.out_valid, bus.out_result, want[k]);
            end
        end
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [0:7];
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic        exp_we;
        ops[0] = ALU_AND; ops[1] = ALU_OR;  ops[2] = ALU_ADD; ops[3] = ALU_SUB;
        ops[4] = ALU_SLT; ops[5] = ALU_NOR; ops[6] = 4'd3;    ops[7] = 4'd15;
        for (int i = 0; i < 40; i++) begin
            set_instr(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(1, 31)),
                      $urandom, $urandom, $urandom, $urandom);
            set_fwd(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
            if (i % 5 == 0) bus.read_data2 = bus.read_data1;
            exp_res = ref_alu(bus.alu_ctrl, ref_a(), ref_b());
            exp_rd  = bus.rd;
            exp_we  = bus.reg_write;
            bus.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== exp_res || bus.out_rd !== exp_rd || bus.out_reg_write !== exp_we) begin
                errors++;
                $display("FAIL b2b_%0d got v %b res %h rd %0d we %b want 1 %h %0d %b", i,
                         bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, exp_res, exp_rd, exp_we);
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_muldiv();
        logic [3:0]  c_tab [0:11];
        logic [31:0] a_tab [0:11];
        logic [31:0] b_tab [0:11];
        logic [31:0] exp_res;
        logic        bad;
        c_tab[0] = ALU_MUL;  a_tab[0] = 32'hFFFF_FFFF; b_tab[0] = 32'd2;
        c_tab[1] = ALU_MULHU; a_tab[1] = 32'hFFFF_FFFF; b_tab[1] = 32'd2;
        c_tab[2] = ALU_DIVU; a_tab[2] = 32'd100; b_tab[2] = 32'd7;
        c_tab[3] = ALU_REMU; a_tab[3] = 32'd100; b_tab[3] = 32'd7;
        c_tab[4] = ALU_DIVU; a_tab[4] = 32'd9;   b_tab[4] = 32'd0;
        c_tab[5] = ALU_REMU; a_tab[5] = 32'd9;   b_tab[5] = 32'd0;
        for (int i = 6; i < 12; i++) begin
            c_tab[i] = 4'(8 + (i % 4));
            a_tab[i] = $urandom;
            b_tab[i] = (i == 11) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
        end
        for (int i = 0; i < 12; i++) begin
            set_instr(c_tab[i], 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd7, a_tab[i], b_tab[i], 32'd0, 32'd0);
            set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
            exp_res = ref_alu(c_tab[i], a_tab[i], b_tab[i]);
            bus.in_valid = 1'b1;
            @(negedge clk);
            // a different instruction offered while busy must be ignored
            set_instr(ALU_ADD, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9, 32'd1, 32'd1, 32'd0, 32'd0);
            bad = (bus.in_ready !== 1'b0) || (bus.out_valid !== 1'b0);
            for (int c = 1; c <= 33; c++) begin
                @(negedge clk);
                if (c < 33) begin
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
                    if (c == 32) bus.in_valid = 1'b0;
                end
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL md_stall_%0d got early ready/valid want ready 0 valid 0 for 33 cycles", i);
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== exp_res || bus.out_rd !== 5'd7 || bus.out_reg_write !== 1'b1) begin
                errors++;
                $display("FAIL md_result_%0d got v %b res %h rd %0d we %b want 1 %h 7 1", i,
                         bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, exp_res);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL md_ready_%0d got %b want 1", i, bus.in_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL md_single_%0d got out_valid %b want 0", i, bus.out_valid);
            end
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        logic [31:0] d2_tab [0:2];
        logic [31:0] im_tab [0:2];
        logic [31:0] pc_tab [0:2];
        logic        fwd_tab [0:2];
        logic        exp_take;
        logic [31:0] exp_tgt;
        d2_tab[0] = 32'd4; im_tab[0] = 32'd3;          pc_tab[0] = 32'h100; fwd_tab[0] = 1'b0;
        d2_tab[1] = 32'd5; im_tab[1] = 32'd3;          pc_tab[1] = 32'h100; fwd_tab[1] = 1'b0;
        d2_tab[2] = 32'd9; im_tab[2] = 32'hFFFF_FFFE;  pc_tab[2] = 32'h200; fwd_tab[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(ALU_SUB, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd4, d2_tab[i], im_tab[i], pc_tab[i]);
            set_fwd(5'd0, 1'b0, 32'd0, fwd_tab[i] ? 5'd2 : 5'd0, fwd_tab[i], 32'd4);
            exp_take = (ref_a() == ref_b());
            exp_tgt  = pc_tab[i] + (im_tab[i] << 2);
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.branch_taken !== exp_take || bus.flush !== exp_take || bus.out_reg_write !== 1'b0) begin
                errors++;
                $display("FAIL br_flags_%0d got taken %b flush %b we %b want %b %b 0", i,
                         bus.branch_taken, bus.flush, bus.out_reg_write, exp_take, exp_take);
            end
            if (exp_take) begin
                checks++;
                if (bus.branch_target !== exp_tgt) begin
                    errors++;
                    $display("FAIL br_target_%0d got %h want %h", i, bus.branch_target, exp_tgt);
                end
            end
            @(negedge clk);
            checks++;
            if (bus.branch_taken !== 1'b0 || bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL br_pulse_%0d got taken %b flush %b want 0 0", i, bus.branch_taken, bus.flush);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic late;
        set_instr(ALU_DIVU, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd6, 32'd1000, 32'd3, 32'd0, 32'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got ready %b valid %b want 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        late = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) late = 1'b1;
        end
        checks++;
        if (late) begin
            errors++;
            $display("FAIL rst_late got a completion or stall after reset want none");
        end
        set_instr(ALU_SUB, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd8, 32'd3, 32'd5, 32'd0, 32'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL rst_recover got valid %b result %h want 1 fffffffe", bus.out_valid, bus.out_result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_back_to_back();
        test_muldiv();
        test_branch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
- Parametrised execute stage: single-cycle ALU plus an iterative multiply/divide unit.
- Includes two-source operand forwarding (MEM, WB), branch resolution with a one-cycle flush pulse, and a registered EX/MEM output.
- Sits between the ID/EX register and the memory stage.
- Stalls the front end through a valid/ready handshake while a multi-cycle operation runs.

Parameters:
- DATA_W, 32, datapath width in bits; also the multiply/divide iteration count.
- REG_AW, 5, register-address width.
- CTRL_W, 4, width of alu_ctrl.

Ports:
- clk  in  1  clock; the block uses one clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  ID/EX holds an instruction.
- in_ready  out  1  stage can accept; low while multiply/divide is busy.
- alu_ctrl  in  CTRL_W  operation select.
- alu_src  in  1  1 selects imm as operand B; 0 selects read_data2.
- branch  in  1  instruction is a branch-if-equal.
- reg_write  in  1  instruction writes rd.
- rs, rt, rd  in  REG_AW  source and destination register indices.
- read_data1, read_data2  in  DATA_W  register file operands.
- imm  in  DATA_W  sign-extended immediate.
- pc  in  DATA_W  incremented PC.
- mem_rd, wb_rd  in  REG_AW  destination registers of the MEM and WB stages.
- mem_reg_write, wb_reg_write  in  1  write enables of the MEM and WB stages.
- mem_result, wb_value  in  DATA_W  forwardable values.
- out_valid  out  1  EX/MEM register holds a valid result.
- out_rd  out  REG_AW  registered destination.
- out_reg_write  out  1  registered write enable, gated by out_valid.
- out_result  out  DATA_W  registered result.
- branch_taken  out  1  one-cycle pulse.
- branch_target  out  DATA_W  pc + (imm << 2), registered with branch_taken.
- flush  out  1  equals branch_taken.

Behaviour:
- Reset: all outputs 0, in_ready 1, FSM in IDLE, counter 0.
- Reset asserted mid-operation abandons the operation; no out_valid is produced for it.
- Forwarding is combinational and evaluated at accept. For each of operands A and B:
  - MEM is used if mem_reg_write && mem_rd != 0 && mem_rd == src.
  - Otherwise WB is used if wb_reg_write && wb_rd != 0 && wb_rd == src.
  - Otherwise the register value is used. MEM has priority over WB.
- Operand B: forwarding applies to rt only when alu_src = 0; imm is never forwarded.
- Accept occurs on a clock edge with in_valid && in_ready.
- Single-cycle ops (latency 1, result visible on the edge after accept):
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 12 NOR.
  - Arithmetic wraps modulo 2^DATA_W.
- Multi-cycle ops:
  - 8 MUL (low DATA_W bits).
  - 9 MULHU (high DATA_W bits, unsigned).
  - 10 DIVU, 11 REMU.
- Undefined codes produce result 0.
- FSM states:
  - IDLE: in_ready = 1. Accepting a multi-cycle op latches operands, sets counter to DATA_W, and moves to BUSY.
  - BUSY: in_ready = 0. One shift-add or restoring-subtract step per cycle; counter decrements. At counter 1 the FSM moves to DONE.
  - DONE: in_ready = 0. Writes the EX/MEM register (out_valid = 1) and returns to IDLE.
- Multi-cycle latency: out_valid asserts DATA_W + 1 edges after accept; in_ready returns to 1 in the cycle after that.
- Division by zero: DIVU returns all ones; REMU returns the dividend.
- Stall cycles with no completion: out_valid = 0 and out_reg_write = 0; out_result holds its last value.
- Branch:
  - Zero flag is (A − B) == 0 on forwarded operands, with alu_ctrl = SUB.
  - On accept with branch && zero, branch_taken and flush pulse for exactly one cycle, together with branch_target.
  - The branch itself writes nothing: out_reg_write = 0.
- Simultaneous in_valid while BUSY: ignored; upstream must hold its instruction.

Decomposition:
- Shared package exec_pkg holds the alu_ctrl encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU) and the FSM state enum (S_IDLE, S_BUSY, S_DONE).
- One sub-module, exec_muldiv, contains the iterative multiply/divide datapath and counter, with start/done handshake.
- Forwarding and ALU logic stay inline.

Test Plan:
- ADD, DATA_W = 32:
  - read_data1 = 5, read_data2 = 7, no forwarding → out_result = 12, out_valid = 1 one edge after accept.
- Forward priority:
  - rs = 3, mem_rd = 3 (mem_result = 0xAA), wb_rd = 3 (wb_value = 0xBB), alu OR with 0 → result 0xAA.
  - Same with mem_rd = 0 → result 0xBB.
- MUL:
  - 0xFFFF_FFFF × 2 → MUL = 0xFFFF_FFFE, MULHU = 1.
  - in_ready low for 33 cycles; out_valid exactly 33 edges after accept.
- DIVU:
  - 100 / 7 → 14; REMU → 2.
  - 9 / 0 → 0xFFFF_FFFF; REMU → 9.
- Branch:
  - A = B = 4, branch = 1, pc = 0x100, imm = 3 → branch_taken = flush = 1 for one cycle, branch_target = 0x10C, out_reg_write = 0.
- Reset mid-DIVU:
  - Assert rst_n low at cycle 10 of BUSY → in_ready = 1, out_valid = 0, and no late completion after release.
